uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO: the core pushes bytes, a baud-rate FSM
// sends them as 8N1 frames (LSB first) and only starts a frame while cts is high.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 10000000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          wr_valid,
   input  logic [7:0]                    wr_data,
   output logic                          wr_ready,
   input  logic                          cts,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int DIV    = CLK_FREQ / BAUD;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_tx_fifo: CLK_FREQ/BAUD must be >= 2");
      end
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
         $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   state_t            r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit;
   logic [7:0]        r_shift;
   logic              r_txd;

   logic              w_push;
   logic              w_pop;
   logic              w_baud_end;
   state_t            w_state_nxt;
   logic [BAUD_W-1:0] w_baud_nxt;
   logic [2:0]        w_bit_nxt;
   logic [7:0]        w_shift_nxt;
   logic              w_txd_nxt;

   assign wr_ready   = (r_count < CNT_W'(FIFO_DEPTH));
   assign busy       = (r_state != S_IDLE) || (r_count != '0);
   assign txd        = r_txd;
   assign fifo_count = r_count;

   assign w_push     = wr_valid && wr_ready;
   assign w_baud_end = (r_baud == BAUD_W'(DIV - 1));

   // FIFO storage holds no control state, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_txd   <= w_txd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_shift <= w_shift_nxt;
   end

   // txd is registered from the next-state decision so the line changes on
   // the same edge as the state it belongs to.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_txd_nxt   = r_txd;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_txd_nxt = 1'b1;
            if ((r_count != '0) && cts) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_mem[r_rd_ptr];
               w_baud_nxt  = '0;
               w_state_nxt = S_START;
               w_txd_nxt   = 1'b0;
            end
         end
         S_START: begin
            w_txd_nxt = 1'b0;
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = S_DATA;
               w_txd_nxt   = r_shift[0];
            end else begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_baud_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_txd_nxt   = 1'b1;
               end else begin
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_bit_nxt   = r_bit + 3'd1;
                  w_txd_nxt   = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end
         end
         S_STOP: begin
            w_txd_nxt = 1'b1;
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10: frame timing, FIFO full/wrap,
// cts gating, asynchronous reset and a serial decoder for end-to-end data.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rstn;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       cts;
   logic       txd;
   logic       busy;
   logic [3:0] fifo_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   uart_tx_fifo #(
      .CLK_FREQ   (100000000),
      .BAUD       (10000000),
      .FIFO_DEPTH (8)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .cts        (cts),
      .txd        (txd),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Serial decoder: enter on a falling edge, returns mid-stop-bit.
   task automatic uart_rx(output logic [7:0] b, output int t0);
      int w;
      w  = 0;
      b  = '0;
      t0 = -1;
      while (txd !== 1'b0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      check_eq("rx_start_seen", {31'd0, txd}, 32'd0);
      if (txd === 1'b0) begin
         t0 = cyc;
         repeat (5) @(negedge clk);
         check_eq("rx_start_bit", {31'd0, txd}, 32'd0);
         for (int k = 0; k < 8; k++) begin
            repeat (10) @(negedge clk);
            b[k] = txd;
         end
         repeat (10) @(negedge clk);
         check_eq("rx_stop_bit", {31'd0, txd}, 32'd1);
      end
   endtask

   task automatic watch_idle(input int n, output int lows);
      lows = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       s  [0:100];
      logic       bs [0:100];
      logic [9:0] wbits;
      logic [7:0] b;
      int         t  [0:19];
      int         t0;
      int         lows;
      int         sent;
      int         guard;

      rstn = 1'b0; wr_valid = 1'b0; wr_data = '0; cts = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_txd", {31'd0, txd}, 32'd1);
      check_eq("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_count", {28'd0, fifo_count}, 32'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single 0x55 frame, latency and exact bit timing
      push(8'h55);
      check_eq("t1_count_after_push", {28'd0, fifo_count}, 32'd1);
      check_eq("t1_txd_after_push", {31'd0, txd}, 32'd1);
      @(negedge clk);
      check_eq("t1_count_after_pop", {28'd0, fifo_count}, 32'd0);
      s[0] = txd; bs[0] = busy;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         s[k] = txd; bs[k] = busy;
      end
      for (int j = 0; j < 10; j++) begin
         for (int m = 0; m < 10; m++) wbits[m] = s[10*j + m];
         if (j == 0)      check_eq("t1_start_bit", {22'd0, wbits}, 32'h000);
         else if (j == 9) check_eq("t1_stop_bit", {22'd0, wbits}, 32'h3FF);
         else             check_eq("t1_data_bit", {22'd0, wbits}, (j % 2 == 1) ? 32'h3FF : 32'h000);
      end
      check_eq("t1_idle_txd", {31'd0, s[100]}, 32'd1);
      check_eq("t1_busy_in_stop", {31'd0, bs[99]}, 32'd1);
      check_eq("t1_busy_idle", {31'd0, bs[100]}, 32'd0);
      repeat (5) @(negedge clk);

      // 2: fill with cts low, overflow dropped, then drain with 101-cycle spacing
      cts = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr_data  = 8'(i);
         wr_valid = 1'b1;
         @(negedge clk);
         if (i == 7) begin
            check_eq("t2_wr_ready_full", {31'd0, wr_ready}, 32'd0);
            check_eq("t2_count_full", {28'd0, fifo_count}, 32'd8);
         end
      end
      wr_valid = 1'b0;
      check_eq("t2_count_after_ovf", {28'd0, fifo_count}, 32'd8);
      check_eq("t2_txd_held", {31'd0, txd}, 32'd1);
      cts = 1'b1;
      for (int i = 0; i < 8; i++) begin
         uart_rx(b, t[i]);
         check_eq("t2_rx_byte", {24'd0, b}, 32'(i));
         if (i > 0) check_eq("t2_spacing", 32'(t[i] - t[i-1]), 32'd101);
      end
      watch_idle(150, lows);
      check_eq("t2_no_ninth_frame", 32'(lows), 32'd0);
      check_eq("t2_count_empty", {28'd0, fifo_count}, 32'd0);

      // 3: cts dropped mid-frame; frame completes, next byte waits
      cts = 1'b0;
      push(8'hA3);
      push(8'h11);
      check_eq("t3_count", {28'd0, fifo_count}, 32'd2);
      cts = 1'b1;
      fork
         uart_rx(b, t0);
         begin
            repeat (45) @(negedge clk);
            cts = 1'b0;
         end
      join
      check_eq("t3_rx_A3", {24'd0, b}, 32'hA3);
      watch_idle(200, lows);
      check_eq("t3_held_by_cts", 32'(lows), 32'd0);
      check_eq("t3_count_waiting", {28'd0, fifo_count}, 32'd1);
      check_eq("t3_busy_waiting", {31'd0, busy}, 32'd1);
      cts = 1'b1;
      uart_rx(b, t0);
      check_eq("t3_rx_11", {24'd0, b}, 32'h11);
      repeat (10) @(negedge clk);

      // 4: asynchronous reset in the middle of a 0xFF data phase
      cts = 1'b0;
      push(8'hFF);
      push(8'h01);
      push(8'h02);
      push(8'h03);
      cts = 1'b1;
      repeat (30) @(negedge clk);
      check_eq("t4_mid_frame_busy", {31'd0, busy}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      check_eq("t4_rst_txd", {31'd0, txd}, 32'd1);
      check_eq("t4_rst_count", {28'd0, fifo_count}, 32'd0);
      check_eq("t4_rst_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      watch_idle(300, lows);
      check_eq("t4_silent_after_rst", 32'(lows), 32'd0);
      check_eq("t4_count_after_rst", {28'd0, fifo_count}, 32'd0);

      // 5: push and pop on the same edge, then 20 bytes across pointer wrap
      cts = 1'b0;
      for (int i = 0; i < 7; i++) push(8'h30 + 8'(i));
      check_eq("t5_count_7", {28'd0, fifo_count}, 32'd7);
      cts      = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h37;
      @(negedge clk);
      wr_valid = 1'b0;
      check_eq("t5_push_pop_count", {28'd0, fifo_count}, 32'd7);
      check_eq("t5_frame_started", {31'd0, txd}, 32'd0);
      sent  = 8;
      guard = 0;
      fork
         begin
            while (sent < 20 && guard < 5000) begin
               if (wr_ready) begin
                  wr_valid = 1'b1;
                  wr_data  = 8'h30 + 8'(sent);
                  sent++;
               end else begin
                  wr_valid = 1'b0;
               end
               @(negedge clk);
               guard++;
            end
            wr_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 20; i++) begin
               uart_rx(b, t0);
               check_eq("t5_rx_order", {24'd0, b}, 32'h30 + 32'(i));
            end
         end
      join
      check_eq("t5_all_pushed", 32'(sent), 32'd20);
      repeat (10) @(negedge clk);

      // 6: "Hi\n" end to end through the decoder
      fork
         begin
            push(8'h48);
            push(8'h69);
            push(8'h0A);
         end
         begin
            uart_rx(b, t0);
            check_eq("t6_rx_0", {24'd0, b}, 32'h48);
            uart_rx(b, t0);
            check_eq("t6_rx_1", {24'd0, b}, 32'h69);
            uart_rx(b, t0);
            check_eq("t6_rx_2", {24'd0, b}, 32'h0A);
         end
      join
      repeat (10) @(negedge clk);
      check_eq("t6_idle_busy", {31'd0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
